mdu_seq: RTL
============

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start  input  1  one-cycle request to launch a multi-cycle op encoded on mdu_op.
REQ-004 SHALL have port mdu_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFSEL.
REQ-005 SHALL have port mf_lo  input  1  read select for mdu_out: 1 = LO, 0 = HI.
REQ-006 SHALL have port d1  input  32  rs operand (dividend/multiplicand; source value for MTHI/MTLO).
REQ-007 SHALL have port d2  input  32  rt operand (divisor/multiplier).
REQ-008 SHALL have port busy  output  1  registered; high while a MULT/DIV sequence is in flight.
REQ-009 SHALL have port real_busy  output  1  combinational; start OR busy; drives the D-stage stall of any HI/LO-using instruction.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.
REQ-012 SHALL have port mdu_out  output  32  combinational; mf_lo ? lo : hi.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV.
REQ-014 In IDLE with start=1 and mdu_op in {MULT, MULTU}: SHALL latch d1 and d2, load cnt=5, and go to MUL.
REQ-015 In IDLE with start=1 and mdu_op in {DIV, DIVU}: SHALL latch d1 and d2, load cnt=10, and go to DIV.
REQ-016 start=1 with mdu_op in {NONE, MTHI, MTLO, MFSEL} SHALL NOT leave IDLE.
REQ-017 In MUL/DIV: SHALL decrement cnt once per cycle; when cnt reaches 1, SHALL commit the result to hi/lo on that edge and return to IDLE.
REQ-018 Latency: start accepted at edge N -> busy=1 from edge N through edge N+L-1 -> hi/lo updated and busy=0 at edge N+L (L = 5 for mul, 10 for div).
REQ-019 MULT: {hi,lo} SHALL be the signed 64-bit product of the latched operands.
REQ-020 MULTU: {hi,lo} SHALL be the unsigned 64-bit product of the latched operands.
REQ-021 DIV: lo SHALL be the signed quotient truncated toward zero; hi SHALL be the remainder, carrying the sign of the dividend.
REQ-022 DIVU: lo SHALL be the unsigned quotient; hi SHALL be the unsigned remainder.
REQ-023 Divisor = 0 (DIV/DIVU): sequence SHALL still run the full 10 cycles; hi/lo SHALL remain unchanged.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: SHALL give lo=0x80000000, hi=0 (no trap).
REQ-025 The result SHALL be computed from the operands latched at start; d1/d2 changes during busy SHALL have no effect.
REQ-026 MTHI (start=1, IDLE): hi <= d1 at the same edge; MTLO likewise for lo; neither SHALL assert busy.
REQ-027 start=1 while busy=1 SHALL be ignored (no relaunch, no MTHI/MTLO write); upstream guarantees it via real_busy.
REQ-028 mdu_out SHALL reflect the current hi/lo registers, including the committed value on the cycle after completion.
REQ-029 Multiply/divide SHALL use behavioural * / % on the latched operands; the countdown only models latency.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the latched operands.
REQ-031 reset SHALL take priority over start and over an in-flight completion; an aborted op SHALL never commit.
REQ-032 real_busy SHALL equal start on the cycle after reset (busy already 0).

Verification
REQ-033 MULT d1=0xFFFFFFFE (-2), d2=3: busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-034 DIVU d1=100, d2=7: busy high for 10 cycles, then lo=14, hi=2; DIV d1=-7, d2=2 then gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 MTLO d1=0x1234 followed by DIV with d2=0: lo=0x1234 immediately; after 10 busy cycles hi/lo are unchanged.
REQ-036 MULTU start, then a second start (MTHI d1=0xAA) at cycle 2: the second start is ignored; hi/lo = first product; hi≠0xAA.
REQ-037 DIV start, reset asserted at cycle 6: next edge busy=0, hi=lo=0; no later commit.
REQ-038 During a mul, toggle d1/d2 every cycle: the result equals the product of the operands presented at start; real_busy=1 on the start cycle and on every busy cycle.

Source files
------------

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// A down-counter models MULT/DIV latency; the arithmetic itself is behavioural.
module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        mf_lo,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        busy,
  output logic        real_busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFSEL
  } op_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        busy_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] a, a_n, b, b_n;
  logic        sgn, sgn_n;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo, rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // MIN_INT / -1 is handled explicitly so the wrap to 0x80000000 never relies
  // on the simulator's treatment of signed division overflow.
  always_comb begin
    quo = '0;
    rem = '0;
    if (b != '0) begin
      if (sgn) begin
        if (b == '1) begin
          quo = 32'd0 - a;
          rem = '0;
        end else begin
          quo = $signed(a) / $signed(b);
          rem = $signed(a) % $signed(b);
        end
      end else begin
        quo = a / b;
        rem = a % b;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    hi_n    = hi;
    lo_n    = lo;
    a_n     = a;
    b_n     = b;
    sgn_n   = sgn;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              a_n     = d1;
              b_n     = d2;
              sgn_n   = (mdu_op == OP_MULT);
              cnt_n   = 4'd5;
              state_n = MUL;
              busy_n  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              a_n     = d1;
              b_n     = d2;
              sgn_n   = (mdu_op == OP_DIV);
              cnt_n   = 4'd10;
              state_n = DIV;
              busy_n  = 1'b1;
            end
            OP_MTHI: hi_n = d1;
            OP_MTLO: lo_n = d1;
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          {hi_n, lo_n} = sgn ? prod_s : prod_u;
          state_n      = IDLE;
          busy_n       = 1'b0;
        end
      end
      DIV: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (b != '0) begin
            hi_n = rem;
            lo_n = quo;
          end
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a     <= '0;
      b     <= '0;
      sgn   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      hi    <= hi_n;
      lo    <= lo_n;
      a     <= a_n;
      b     <= b_n;
      sgn   <= sgn_n;
    end
  end

  assign real_busy = start | busy;
  assign mdu_out   = mf_lo ? lo : hi;

endmodule
